// File: rtl/sevseg_capture.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment bus: synchronises the
// bus, waits for a stable single-digit pattern, decodes it and keeps per-digit status.
module sevseg_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT_W     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] valid,
  output logic [3:0] blank,
  output logic [3:0] err,
  output logic       update,
  output logic [1:0] update_idx,
  output logic       frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] STALE_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] STALE_NEAR = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  // Sampled word layout: [11:8] an, [7:1] a..g, [0] dp
  logic [11:0] bus_w, s1, s2, prev;
  logic [CW-1:0] cnt;
  logic [3:0] an_low;
  logic       one_low;
  logic       stable;
  logic       capture;
  logic [1:0] cap_idx;
  logic [6:0] leds;
  logic [4:0] dec;
  logic [3:0] seen, seen_next;
  logic [3:0] out_r [4];
  logic [TIMEOUT_W-1:0] stale [4];

  function automatic logic [4:0] decode(input logic [6:0] l);
    logic [4:0] r;
    r = 5'b0;
    case (l)
      7'b1111110: r = 5'h10;
      7'b0110000: r = 5'h11;
      7'b1101101: r = 5'h12;
      7'b1111001: r = 5'h13;
      7'b0110011: r = 5'h14;
      7'b1011011: r = 5'h15;
      7'b1011111: r = 5'h16;
      7'b1110000: r = 5'h17;
      7'b1111111: r = 5'h18;
      7'b1111011: r = 5'h19;
      7'b1110111: r = 5'h1A;
      7'b0011111: r = 5'h1B;
      7'b1001110: r = 5'h1C;
      7'b0111101: r = 5'h1D;
      7'b1001111: r = 5'h1E;
      7'b1000111: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  assign bus_w = {an, a, b, c, d, e, f, g, dp};

  always_comb begin
    an_low    = ~s2[11:8];
    one_low   = (an_low != 4'b0) && ((an_low & (an_low - 4'd1)) == 4'b0);
    stable    = (s2 == prev) && one_low;
    capture   = stable && (cnt == CNT_LAST);
    leds      = ~s2[7:1];
    dec       = decode(leds);
    cap_idx   = 2'd0;
    case (an_low)
      4'b0010: cap_idx = 2'd1;
      4'b0100: cap_idx = 2'd2;
      4'b1000: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
    seen_next = seen | (4'b0001 << cap_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '1;
      s2   <= '1;
      prev <= '1;
      cnt  <= '0;
    end else begin
      s1   <= bus_w;
      s2   <= s1;
      prev <= s2;
      if (!stable)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update     <= 1'b0;
      update_idx <= 2'd0;
      frame_done <= 1'b0;
      seen       <= 4'b0;
      valid      <= 4'b0;
      blank      <= 4'b0;
      err        <= 4'b0;
      for (int i = 0; i < 4; i++) begin
        out_r[i] <= 4'd0;
        stale[i] <= '0;
      end
    end else begin
      update     <= capture;
      frame_done <= 1'b0;
      if (capture) begin
        update_idx <= cap_idx;
        if (seen_next == 4'b1111) begin
          frame_done <= 1'b1;
          seen       <= 4'b0;
        end else begin
          seen <= seen_next;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (capture && cap_idx == 2'(i)) begin
          // A capture always wins over a simultaneous staleness expiry
          stale[i] <= '0;
          if (dec[4]) begin
            out_r[i] <= dec[3:0];
            valid[i] <= 1'b1;
            blank[i] <= 1'b0;
            err[i]   <= 1'b0;
          end else if (leds == 7'b0) begin
            valid[i] <= 1'b0;
            blank[i] <= 1'b1;
            err[i]   <= 1'b0;
          end else begin
            valid[i] <= 1'b0;
            blank[i] <= 1'b0;
            err[i]   <= 1'b1;
          end
        end else begin
          if (stale[i] != STALE_MAX)
            stale[i] <= stale[i] + 1'b1;
          if (stale[i] >= STALE_NEAR) begin
            valid[i] <= 1'b0;
            blank[i] <= 1'b0;
            err[i]   <= 1'b0;
          end
        end
      end
    end
  end

  assign out0 = out_r[0];
  assign out1 = out_r[1];
  assign out2 = out_r[2];
  assign out3 = out_r[3];

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture with short stability/timeout parameters; captures
// are predicted into a queue and checked when update pulses.
module tb_sevseg_capture;

  localparam int S = 4;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, c, d, e, f, g, dp;
  logic [3:0] an;
  logic [3:0] out0, out1, out2, out3;
  logic [3:0] valid, blank, err;
  logic       update, frame_done;
  logic [1:0] update_idx;

  int errors = 0;
  int checks = 0;

  // Entry: {idx[1:0], value[3:0], valid/blank/err[2:0], frame_done}
  logic [9:0] exp_q[$];
  logic [9:0] ent;
  logic [3:0] sel_out;
  logic       found;

  sevseg_capture #(.STABLE_CYCLES(S), .TIMEOUT_W(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid(valid), .blank(blank), .err(err),
    .update(update), .update_idx(update_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] l;
    case (v)
      4'h0: l = 7'b1111110;  4'h1: l = 7'b0110000;
      4'h2: l = 7'b1101101;  4'h3: l = 7'b1111001;
      4'h4: l = 7'b0110011;  4'h5: l = 7'b1011011;
      4'h6: l = 7'b1011111;  4'h7: l = 7'b1110000;
      4'h8: l = 7'b1111111;  4'h9: l = 7'b1111011;
      4'hA: l = 7'b1110111;  4'hB: l = 7'b0011111;
      4'hC: l = 7'b1001110;  4'hD: l = 7'b0111101;
      4'hE: l = 7'b1001111;  default: l = 7'b1000111;
    endcase
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] an_v, input logic [6:0] leds);
    an = an_v;
    {a, b, c, d, e, f, g} = ~leds;
    dp = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: every update pulse is matched against the oldest prediction
  always @(negedge clk) begin
    if (rst_n === 1'b1 && update === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_update", 32'(update_idx), 32'hFF);
      end else begin
        ent = exp_q.pop_front();
        case (ent[9:8])
          2'd0: sel_out = out0;
          2'd1: sel_out = out1;
          2'd2: sel_out = out2;
          default: sel_out = out3;
        endcase
        chk("upd_idx", 32'(update_idx), 32'(ent[9:8]));
        chk("upd_out", 32'(sel_out), 32'(ent[7:4]));
        chk("upd_vbe", 32'({valid[ent[9:8]], blank[ent[9:8]], err[ent[9:8]]}), 32'(ent[3:1]));
        chk("upd_frame", 32'(frame_done), 32'(ent[0]));
      end
    end else if (rst_n === 1'b1 && frame_done === 1'b1) begin
      chk("frame_without_update", 32'(frame_done), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(4'b1111, 7'b0);
    tick(3);
    chk("rst_outs", 32'({out3, out2, out1, out0}), 32'h0);
    chk("rst_status", 32'({valid, blank, err}), 32'h0);
    chk("rst_pulses", 32'({update, frame_done, update_idx}), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Latency: capture visible after the sixth edge from the first sample
    exp_q.push_back({2'd0, 4'h3, 3'b100, 1'b0});
    drive(4'b1110, glyph(4'h3));
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk("latency", 32'(update), 32'(k == 6));
    end
    chk("t1_out0", 32'(out0), 32'h3);
    chk("t1_valid", 32'(valid), 32'b0001);
    tick(3);

    // Pattern change mid-count restarts stability from the new pattern
    drive(4'b1110, glyph(4'h5));
    tick(3);
    exp_q.push_back({2'd0, 4'h7, 3'b100, 1'b0});
    drive(4'b1110, glyph(4'h7));
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk("restart", 32'(update), 32'(k == 6));
    end
    tick(3);

    // Full frame across all four digits
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'(i), 4'(10 + i), 3'b100, 1'(i == 3)});
      drive(~(4'b0001 << i), glyph(4'(10 + i)));
      tick(10);
    end
    chk("frame_outs", 32'({out3, out2, out1, out0}), 32'hDCBA);
    chk("frame_valid3", 32'(valid[3]), 32'd1);

    // Blank then unrecognised pattern on digit 1; value is held
    exp_q.push_back({2'd1, 4'hB, 3'b010, 1'b0});
    drive(4'b1101, 7'b0000000);
    tick(10);
    chk("blank_bits", 32'(blank & 4'b0010), 32'b0010);
    exp_q.push_back({2'd1, 4'hB, 3'b001, 1'b0});
    drive(4'b1101, 7'b1010101);
    tick(10);
    chk("err_bits", 32'({err[1], blank[1], valid[1]}), 32'b100);
    chk("err_out1", 32'(out1), 32'hB);

    // Staleness: valid[2] drops 15 edges after its capture while the bus idles
    exp_q.push_back({2'd2, 4'h9, 3'b100, 1'b0});
    drive(4'b1011, glyph(4'h9));
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (update === 1'b1) found = 1'b1;
    end
    chk("stale_capture_seen", 32'(found), 32'd1);
    drive(4'b1111, 7'b0);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk("idle_no_update", 32'(update), 32'd0);
      if (k == 14) chk("stale_before", 32'(valid[2]), 32'd1);
      if (k == 15) chk("stale_after", 32'(valid[2]), 32'd0);
    end
    chk("stale_out2_held", 32'(out2), 32'h9);

    // Two anodes low is idle
    drive(4'b1100, glyph(4'h8));
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("multi_low_no_update", 32'(update), 32'd0);
    end

    // Asynchronous reset mid-count discards the pending capture
    drive(4'b1110, glyph(4'h8));
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_outs", 32'({out3, out2, out1, out0}), 32'h0);
    chk("async_status", 32'({valid, blank, err}), 32'h0);
    chk("async_pulses", 32'({update, frame_done, update_idx}), 32'h0);
    drive(4'b1111, 7'b0);
    tick(2);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("post_reset_quiet", 32'(update), 32'd0);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevseg_capture.md
# sevseg_capture

Receive-side monitor for the 4-digit multiplexed seven-segment bus (active-low cathodes a–g, dp, active-low anodes an[3:0]). It samples the bus, waits for each anode/segment pattern to hold stable, and decodes the lit pattern back to a 4-bit hex value. It keeps per-digit value and status registers. It serves display loopback self-test and reading externally driven displays.

## Interface
- STABLE_CYCLES, 16: consecutive identical synchronised samples required before a capture (≥2).
- TIMEOUT_W, 20: per-digit staleness counter width; a digit not refreshed for 2^TIMEOUT_W−1 cycles loses its status.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- a, b, c, d, e, f, g  in  1 each  segment cathodes, active-low (0 = lit).
- dp  in  1  decimal point, active-low; synchronised and ignored for decode.
- an  in  4  digit anodes, active-low; an[i]=0 selects digit i.
- out0, out1, out2, out3  out  4 each  last decoded value per digit.
- valid  out  4  valid[i]=1: out_i holds a recognised hex glyph.
- blank  out  4  blank[i]=1: digit i last captured with all segments off.
- err  out  4  err[i]=1: digit i last captured with an unrecognised pattern.
- update  out  1  one-cycle pulse on every capture.
- update_idx  out  2  digit index of the capture; meaningful while update=1.
- frame_done  out  1  one-cycle pulse when all four digits have been captured since the previous pulse.

## Operation
- Synchroniser: {an, a..g, dp} passes through two flops. These flops reset to all-ones, meaning idle with no digit selected.
- Compare: the sync output word s2 is compared each cycle with register prev, which loads s2 every cycle.
  - If s2 ≠ prev, or an is not exactly one low bit, cnt ← 0.
  - Otherwise cnt ← cnt+1, saturating at STABLE_CYCLES.
- Capture: fires on the edge where cnt goes STABLE_CYCLES−1 → STABLE_CYCLES. There is exactly one capture per stable period, and no further capture until cnt has been cleared.
- Decode: leds = ~{a..g}, MSB = a.
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000.
  - 8:1111111, 9:1111011, A:1110111, b:0011111, C:1001110, d:0111101, E:1001111, F:1000111.
- Capture of digit i, recognised glyph: out_i ← value, valid[i] ← 1, blank[i] ← 0, err[i] ← 0.
- Capture of digit i, leds = 0000000: valid[i] ← 0, blank[i] ← 1, err[i] ← 0; out_i is held.
- Capture of digit i, any other pattern: valid[i] ← 0, blank[i] ← 0, err[i] ← 1; out_i is held.
- Every capture pulses update with update_idx = i.
- Staleness: each digit has a TIMEOUT_W-bit counter.
  - It clears on a capture of that digit and increments otherwise.
  - On reaching all-ones it holds, and clears valid[i], blank[i] and err[i]. out_i is held.
- Frame tracking: the seen[3:0] mask sets bit i on each capture. When seen, including the current capture, becomes 1111, frame_done pulses in the same cycle as update and seen ← 0000.
- Anode states 1111 and any multi-low state are idle. They never capture and they reset cnt.

## Timing
- Reset (async assert, synchronous-safe release) gives:
  - out0..3 = 0, valid = blank = err = 0.
  - update = frame_done = 0, update_idx = 0.
  - cnt = 0, seen = 0, staleness counters = 0, prev = all-ones.
- Latency: a bus change sampled at edge E0 and then held produces capture outputs after edge E0+2+STABLE_CYCLES. With STABLE_CYCLES=16 this is E18.
- update and frame_done are registered. Each is high for exactly one cycle.
- Any bus change, including dp alone, before the capture edge restarts the count from the new pattern.
- Reset mid-count discards the pending capture. Reset mid-pulse drops update and frame_done immediately.
- A capture and a staleness expiry on the same digit in the same cycle resolve to the capture.
- Staleness counters on other digits are unaffected by a capture.

## Test plan
- STABLE_CYCLES=4: hold an=1110, segs = glyph 3 (leds 1111001), starting at E0 → update at E6, update_idx=0, out0=3, valid=0001.
- Change the pattern at E3, then hold → no update until 6 edges after the change; the captured value is the new glyph.
- Cycle digits 0..3 with glyphs A, b, C, d, each held 10 cycles → four update pulses; frame_done together with the digit-3 update; out3..out0 = D, C, B, A.
- an=1101 with leds 0000000, then with leds 1010101 → blank=0010, then err=0010, valid[1]=0, out1 unchanged.
- TIMEOUT_W=4: capture digit 2, then hold an=1111 → valid[2] clears 15 cycles after the capture; no update pulses during idle.
- an=1100 held 20 cycles → no update; assert rst_n=0 mid-count → all outputs return to reset values asynchronously.
